parity_sreg_gen: RTL and testbench

//  Parametrised successor to the S-register/parity slice. Holds the S address register.

---
 rtl/agc_parity_pkg.sv | 20 ++
 rtl/parity_tree.sv | 64 ++++++
 rtl/parity_sreg_gen.sv | 143 ++++++++++++++
 tb/tb_parity_sreg_gen.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/agc_parity_pkg.sv
// Shared definitions for the S-register / G-parity slice: group count helper,
// parity sense and the tag that travels with each word through the parity tree.
package agc_parity_pkg;

   // Parity sense: a word plus its parity bit must contain an odd number of ones.
   localparam logic ODD_PAR = 1'b1;

   // Per-word tag carried alongside the data through every tree stage.
   typedef struct packed {
      logic vld;
      logic chk;
      logic par_in;
   } par_tag_t;

   // Number of partial-parity groups; the last group may be short.
   function automatic int ng(input int data_w, input int group_w);
      return (data_w + group_w - 1) / group_w;
   endfunction

endpackage

// File: rtl/parity_tree.sv
// Group-partitioned odd-parity tree. Each group is XOR-reduced, the group
// vector passes through PIPE register stages together with the word's tag,
// and the final XOR happens after the last stage.
module parity_tree
   import agc_parity_pkg::*;
#(
   parameter int DATA_W  = 15,
   parameter int GROUP_W = 3,
   parameter int PIPE    = 1,
   localparam int NG     = ng(DATA_W, GROUP_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_i,
   input  par_tag_t          tag_i,
   output logic [NG-1:0]     grp_o,
   output logic              par_o,
   output par_tag_t          tag_o
);

   logic [NG-1:0] grp_c;
   logic [NG-1:0] grp_out;

   // Partial parity per group; the final group covers whatever bits remain.
   for (genvar g = 0; g < NG; g++) begin : g_grp
      localparam int LO = g * GROUP_W;
      localparam int W  = (LO + GROUP_W > DATA_W) ? (DATA_W - LO) : GROUP_W;
      assign grp_c[g] = ^data_i[LO +: W];
   end

   assign grp_o = grp_c;

   if (PIPE == 0) begin : g_comb
      assign grp_out = grp_c;
      assign tag_o   = tag_i;
   end else begin : g_pipe
      logic [NG-1:0] grp_q [PIPE];
      par_tag_t      tag_q [PIPE];

      // Shift group parity and tag together; reset discards in-flight words.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s < PIPE; s++) begin
               grp_q[s] <= '0;
               tag_q[s] <= '0;
            end
         end else begin
            grp_q[0] <= grp_c;
            tag_q[0] <= tag_i;
            for (int s = 1; s < PIPE; s++) begin
               grp_q[s] <= grp_q[s-1];
               tag_q[s] <= tag_q[s-1];
            end
         end
      end

      assign grp_out = grp_q[PIPE-1];
      assign tag_o   = tag_q[PIPE-1];
   end

   // Odd parity: invert the even XOR of all groups.
   assign par_o = ODD_PAR ^ (^grp_out);

endmodule

// File: rtl/parity_sreg_gen.sv
// S address register plus G-word parity generator/checker. Captured G words
// are tagged with their check flag and incoming parity, run through the
// parity tree, and checked faults drive a pulse, a saturating counter and a
// sticky alarm.
module parity_sreg_gen
   import agc_parity_pkg::*;
#(
   parameter int DATA_W  = 15,
   parameter int ADDR_W  = 12,
   parameter int GROUP_W = 3,
   parameter int PIPE    = 1,
   parameter int CNT_W   = 4,
   localparam int NG     = ng(DATA_W, GROUP_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_clear,
   input  logic              s_load,
   input  logic [ADDR_W-1:0] s_data,
   input  logic              g_load,
   input  logic [DATA_W-1:0] g_data,
   input  logic              g_par_in,
   input  logic              g_chk,
   input  logic              par_inh,
   input  logic              alarm_clr,
   output logic [ADDR_W-1:0] s_q,
   output logic              s_zero,
   output logic [2:0]        s_ead,
   output logic [DATA_W-1:0] g_q,
   output logic [NG-1:0]     grp_par,
   output logic              par_valid,
   output logic              par_gen,
   output logic              par_err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              par_alarm
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [ADDR_W-1:0] s_d;
   logic [DATA_W-1:0] g_d;
   par_tag_t          cap_tag_q, cap_tag_d;
   par_tag_t          res_tag;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic              alarm_q, alarm_d;
   logic              fault;

   // S next state: clear has priority over load.
   always_comb begin
      s_d = s_q;
      if (s_clear) begin
         s_d = '0;
      end else if (s_load) begin
         s_d = s_data;
      end
   end

   // S register.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q <= '0;
      end else begin
         s_q <= s_d;
      end
   end

   assign s_zero = (s_q == '0);
   assign s_ead  = s_q[ADDR_W-1 -: 3];

   // G capture next state: valid pulses once per load, chk/par tag held with the word.
   always_comb begin
      g_d           = g_q;
      cap_tag_d     = cap_tag_q;
      cap_tag_d.vld = g_load;
      if (g_load) begin
         g_d              = g_data;
         cap_tag_d.chk    = g_chk;
         cap_tag_d.par_in = g_par_in;
      end
   end

   // G shadow and its tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         g_q       <= '0;
         cap_tag_q <= '0;
      end else begin
         g_q       <= g_d;
         cap_tag_q <= cap_tag_d;
      end
   end

   parity_tree #(
      .DATA_W  (DATA_W),
      .GROUP_W (GROUP_W),
      .PIPE    (PIPE)
   ) u_tree (
      .clk    (clk),
      .rst    (rst),
      .data_i (g_q),
      .tag_i  (cap_tag_q),
      .grp_o  (grp_par),
      .par_o  (par_gen),
      .tag_o  (res_tag)
   );

   // Inhibit is looked at in the result cycle, not at capture time.
   assign par_valid = res_tag.vld;
   assign fault     = (par_gen != res_tag.par_in);
   assign par_err   = par_valid & res_tag.chk & fault & ~par_inh;

   // Counter/alarm next state: a fault in the same cycle as a clear wins.
   always_comb begin
      err_cnt_d = err_cnt_q;
      alarm_d   = alarm_q;
      if (par_err) begin
         alarm_d = 1'b1;
         if (alarm_clr) begin
            err_cnt_d = CNT_W'(1);
         end else if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
      end else if (alarm_clr) begin
         err_cnt_d = '0;
         alarm_d   = 1'b0;
      end
   end

   // Saturating fault counter and sticky alarm.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
         alarm_q   <= 1'b0;
      end else begin
         err_cnt_q <= err_cnt_d;
         alarm_q   <= alarm_d;
      end
   end

   assign err_cnt   = err_cnt_q;
   assign par_alarm = alarm_q;

endmodule

// File: tb/tb_parity_sreg_gen.sv
// Directed bench for parity_sreg_gen: default instance (15-bit word, PIPE=1)
// plus three 16-bit/4-bit-group instances with PIPE=0,1,2 for the sweep.
module tb_parity_sreg_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic        rst, s_clear, s_load, g_load, g_par_in, g_chk, par_inh, alarm_clr;
   logic [11:0] s_data;
   logic [14:0] g_data;
   logic [11:0] s_q;
   logic        s_zero;
   logic [2:0]  s_ead;
   logic [14:0] g_q;
   logic [4:0]  grp_par;
   logic        par_valid, par_gen, par_err, par_alarm;
   logic [3:0]  err_cnt;

   parity_sreg_gen u_dut (
      .clk(clk), .rst(rst), .s_clear(s_clear), .s_load(s_load), .s_data(s_data),
      .g_load(g_load), .g_data(g_data), .g_par_in(g_par_in), .g_chk(g_chk),
      .par_inh(par_inh), .alarm_clr(alarm_clr), .s_q(s_q), .s_zero(s_zero),
      .s_ead(s_ead), .g_q(g_q), .grp_par(grp_par), .par_valid(par_valid),
      .par_gen(par_gen), .par_err(par_err), .err_cnt(err_cnt), .par_alarm(par_alarm)
   );

   logic        sw_load;
   logic [15:0] sw_data;
   logic [11:0] sw_s_q   [3];
   logic        sw_s_zero[3];
   logic [2:0]  sw_s_ead [3];
   logic [15:0] sw_g_q   [3];
   logic [3:0]  sw_grp   [3];
   logic        sw_vld   [3];
   logic        sw_gen   [3];
   logic        sw_err   [3];
   logic [3:0]  sw_cnt   [3];
   logic        sw_alarm [3];

   for (genvar p = 0; p < 3; p++) begin : g_sw
      parity_sreg_gen #(.DATA_W(16), .ADDR_W(12), .GROUP_W(4), .PIPE(p), .CNT_W(4)) u_sw (
         .clk(clk), .rst(rst), .s_clear(1'b0), .s_load(1'b0), .s_data(12'd0),
         .g_load(sw_load), .g_data(sw_data), .g_par_in(1'b0), .g_chk(1'b0),
         .par_inh(1'b0), .alarm_clr(1'b0), .s_q(sw_s_q[p]), .s_zero(sw_s_zero[p]),
         .s_ead(sw_s_ead[p]), .g_q(sw_g_q[p]), .grp_par(sw_grp[p]), .par_valid(sw_vld[p]),
         .par_gen(sw_gen[p]), .par_err(sw_err[p]), .err_cnt(sw_cnt[p]), .par_alarm(sw_alarm[p])
      );
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word for a single cycle; returns one cycle later with g_load low.
   task automatic send_word(input logic [14:0] d, input logic par, input logic chk);
      g_load = 1'b1; g_data = d; g_par_in = par; g_chk = chk;
      step();
      g_load = 1'b0;
   endtask

   function automatic logic [3:0] ref_grp16(input logic [15:0] d);
      logic [3:0] r;
      r = '0;
      for (int g = 0; g < 4; g++)
         for (int b = 0; b < 4; b++)
            r[g] = r[g] ^ d[4*g+b];
      return r;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      #1;
      total++; if (s_q !== 12'd0)      begin bad++; $display("FAIL rst_s_q got=%h want=0", s_q); end
      total++; if (s_zero !== 1'b1)    begin bad++; $display("FAIL rst_s_zero got=%b want=1", s_zero); end
      total++; if (g_q !== 15'd0)      begin bad++; $display("FAIL rst_g_q got=%h want=0", g_q); end
      total++; if (par_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", par_valid); end
      total++; if (par_err !== 1'b0)   begin bad++; $display("FAIL rst_err got=%b want=0", par_err); end
      total++; if (err_cnt !== 4'd0)   begin bad++; $display("FAIL rst_cnt got=%h want=0", err_cnt); end
      total++; if (par_alarm !== 1'b0) begin bad++; $display("FAIL rst_alarm got=%b want=0", par_alarm); end
      rst = 1'b0;
   endtask

   task automatic test_sreg();
      s_load = 1'b1; s_data = 12'o4000;
      step();
      s_load = 1'b0;
      #1;
      total++; if (s_q !== 12'o4000)  begin bad++; $display("FAIL s_load got=%o want=4000", s_q); end
      total++; if (s_zero !== 1'b0)   begin bad++; $display("FAIL s_zero_nz got=%b want=0", s_zero); end
      total++; if (s_ead !== 3'b100)  begin bad++; $display("FAIL s_ead_4000 got=%b want=100", s_ead); end
      s_clear = 1'b1; s_load = 1'b1; s_data = 12'o1234;
      step();
      s_clear = 1'b0; s_load = 1'b0;
      #1;
      total++; if (s_q !== 12'd0)     begin bad++; $display("FAIL s_clear_prio got=%o want=0", s_q); end
      total++; if (s_zero !== 1'b1)   begin bad++; $display("FAIL s_zero got=%b want=1", s_zero); end
      s_load = 1'b1; s_data = 12'o5400;
      step();
      s_load = 1'b0;
      #1;
      total++; if (s_q !== 12'o5400)  begin bad++; $display("FAIL s_reload got=%o want=5400", s_q); end
      total++; if (s_ead !== 3'b101)  begin bad++; $display("FAIL s_ead_5400 got=%b want=101", s_ead); end
   endtask

   task automatic test_gen();
      send_word(15'h0000, 1'b0, 1'b0);
      #1;
      total++; if (g_q !== 15'h0000)   begin bad++; $display("FAIL gen0_g_q got=%h want=0", g_q); end
      total++; if (par_valid !== 1'b0) begin bad++; $display("FAIL gen0_early got=%b want=0", par_valid); end
      step(); #1;
      total++; if (par_valid !== 1'b1) begin bad++; $display("FAIL gen0_valid got=%b want=1", par_valid); end
      total++; if (par_gen !== 1'b1)   begin bad++; $display("FAIL gen0_par got=%b want=1", par_gen); end
      total++; if (par_err !== 1'b0)   begin bad++; $display("FAIL gen0_err got=%b want=0", par_err); end
      step(); #1;
      total++; if (par_valid !== 1'b0) begin bad++; $display("FAIL gen0_onecyc got=%b want=0", par_valid); end
      send_word(15'h0001, 1'b1, 1'b0);
      #1;
      total++; if (grp_par !== 5'b00001) begin bad++; $display("FAIL gen1_grp got=%b want=00001", grp_par); end
      step(); #1;
      total++; if (par_valid !== 1'b1) begin bad++; $display("FAIL gen1_valid got=%b want=1", par_valid); end
      total++; if (par_gen !== 1'b0)   begin bad++; $display("FAIL gen1_par got=%b want=0", par_gen); end
      total++; if (par_err !== 1'b0)   begin bad++; $display("FAIL gen1_unchk_err got=%b want=0", par_err); end
      step(); #1;
      total++; if (err_cnt !== 4'd0)   begin bad++; $display("FAIL gen_cnt got=%h want=0", err_cnt); end
   endtask

   task automatic test_check();
      send_word(15'h0001, 1'b0, 1'b1);
      step(); #1;
      total++; if (par_valid !== 1'b1) begin bad++; $display("FAIL chk_ok_valid got=%b want=1", par_valid); end
      total++; if (par_err !== 1'b0)   begin bad++; $display("FAIL chk_ok_err got=%b want=0", par_err); end
      send_word(15'h0001, 1'b1, 1'b1);
      step(); #1;
      total++; if (par_err !== 1'b1)   begin bad++; $display("FAIL chk_bad_err got=%b want=1", par_err); end
      step(); #1;
      total++; if (par_err !== 1'b0)   begin bad++; $display("FAIL chk_pulse got=%b want=0", par_err); end
      total++; if (err_cnt !== 4'd1)   begin bad++; $display("FAIL chk_cnt got=%h want=1", err_cnt); end
      total++; if (par_alarm !== 1'b1) begin bad++; $display("FAIL chk_alarm got=%b want=1", par_alarm); end
      send_word(15'h0001, 1'b1, 1'b1);
      step();
      par_inh = 1'b1;
      #1;
      total++; if (par_valid !== 1'b1) begin bad++; $display("FAIL inh_valid got=%b want=1", par_valid); end
      total++; if (par_err !== 1'b0)   begin bad++; $display("FAIL inh_err got=%b want=0", par_err); end
      step();
      par_inh = 1'b0;
      #1;
      total++; if (err_cnt !== 4'd1)   begin bad++; $display("FAIL inh_cnt got=%h want=1", err_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [14:0] d;
      logic        exp_gen [20];
      int          pulses;
      pulses = 0;
      for (int i = 0; i < 22; i++) begin
         d = 15'(i * 1234 + 7);
         g_load = (i < 20); g_data = d; g_par_in = ^d; g_chk = 1'b1;
         if (i < 20) exp_gen[i] = ~(^d);
         #1;
         if (i >= 2) begin
            total++; if (par_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", i-2, par_valid); end
            total++; if (par_gen !== exp_gen[i-2]) begin bad++; $display("FAIL b2b_gen[%0d] got=%b want=%b", i-2, par_gen, exp_gen[i-2]); end
            if (par_err === 1'b1) pulses++;
         end
         step();
      end
      #1;
      total++; if (pulses != 20)       begin bad++; $display("FAIL b2b_pulses got=%0d want=20", pulses); end
      total++; if (err_cnt !== 4'd15)  begin bad++; $display("FAIL sat_cnt got=%0d want=15", err_cnt); end
      total++; if (par_alarm !== 1'b1) begin bad++; $display("FAIL sat_alarm got=%b want=1", par_alarm); end
      send_word(15'h0005, 1'b0, 1'b1);
      step();
      alarm_clr = 1'b1;
      #1;
      total++; if (par_err !== 1'b1)   begin bad++; $display("FAIL clr_hit_err got=%b want=1", par_err); end
      step();
      alarm_clr = 1'b0;
      #1;
      total++; if (err_cnt !== 4'd1)   begin bad++; $display("FAIL clr_hit_cnt got=%0d want=1", err_cnt); end
      total++; if (par_alarm !== 1'b1) begin bad++; $display("FAIL clr_hit_alarm got=%b want=1", par_alarm); end
      alarm_clr = 1'b1;
      step();
      alarm_clr = 1'b0;
      #1;
      total++; if (err_cnt !== 4'd0)   begin bad++; $display("FAIL clr_cnt got=%0d want=0", err_cnt); end
      total++; if (par_alarm !== 1'b0) begin bad++; $display("FAIL clr_alarm got=%b want=0", par_alarm); end
   endtask

   task automatic test_reset_inflight();
      s_load = 1'b1; s_data = 12'o7777;
      send_word(15'h0001, 1'b1, 1'b1);
      s_load = 1'b0;
      step(); step();
      #1;
      total++; if (err_cnt !== 4'd1)   begin bad++; $display("FAIL pre_rst_cnt got=%0d want=1", err_cnt); end
      g_load = 1'b1; g_data = 15'h0001; g_par_in = 1'b1; g_chk = 1'b1;
      step();
      g_data = 15'h0003;
      step();
      g_load = 1'b0;
      rst = 1'b1;
      step();
      #1;
      total++; if (par_valid !== 1'b0) begin bad++; $display("FAIL rst1_valid got=%b want=0", par_valid); end
      total++; if (err_cnt !== 4'd0)   begin bad++; $display("FAIL rst1_cnt got=%0d want=0", err_cnt); end
      total++; if (s_q !== 12'd0)      begin bad++; $display("FAIL rst1_s_q got=%o want=0", s_q); end
      step();
      rst = 1'b0;
      #1;
      total++; if (g_q !== 15'd0)      begin bad++; $display("FAIL rst2_g_q got=%h want=0", g_q); end
      total++; if (par_alarm !== 1'b0) begin bad++; $display("FAIL rst2_alarm got=%b want=0", par_alarm); end
      total++; if (par_err !== 1'b0)   begin bad++; $display("FAIL rst2_err got=%b want=0", par_err); end
      for (int k = 0; k < 4; k++) begin
         total++; if (par_valid !== 1'b0) begin bad++; $display("FAIL rst_idle_valid[%0d] got=%b want=0", k, par_valid); end
         step(); #1;
      end
   endtask

   task automatic test_sweep();
      logic [15:0] hist [1000];
      int          lat;
      bit          found;
      sw_load = 1'b0;
      for (int p = 0; p < 3; p++) begin
         sw_load = 1'b1; sw_data = 16'hA5A5;
         step();
         sw_load = 1'b0;
         lat = 0; found = 1'b0;
         for (int n = 1; n <= 6 && !found; n++) begin
            if (n > 1) step();
            #1;
            if (sw_vld[p] === 1'b1) begin found = 1'b1; lat = n; end
         end
         total++; if (lat != p + 1) begin bad++; $display("FAIL sweep_lat_p%0d got=%0d want=%0d", p, lat, p + 1); end
         total++; if (sw_gen[p] !== 1'b1) begin bad++; $display("FAIL sweep_gen_p%0d got=%b want=1", p, sw_gen[p]); end
         for (int n = 0; n < 4; n++) step();
      end
      for (int k = 0; k < 1003; k++) begin
         sw_load = (k < 1000);
         sw_data = 16'($urandom);
         if (k < 1000) hist[k] = sw_data;
         #1;
         for (int p = 0; p < 3; p++) begin
            if (k >= 1 && k <= 1000) begin
               total++; if (sw_grp[p] !== ref_grp16(hist[k-1])) begin bad++; $display("FAIL sweep_grp_p%0d[%0d] got=%b want=%b", p, k-1, sw_grp[p], ref_grp16(hist[k-1])); end
            end
            if (k - 1 - p >= 0 && k - 1 - p < 1000) begin
               total++; if (sw_vld[p] !== 1'b1) begin bad++; $display("FAIL sweep_vld_p%0d[%0d] got=%b want=1", p, k-1-p, sw_vld[p]); end
               total++; if (sw_gen[p] !== ~(^hist[k-1-p])) begin bad++; $display("FAIL sweep_par_p%0d[%0d] got=%b want=%b", p, k-1-p, sw_gen[p], ~(^hist[k-1-p])); end
            end
         end
         step();
      end
   endtask

   initial begin
      rst = 1'b1; s_clear = 1'b0; s_load = 1'b0; s_data = '0;
      g_load = 1'b0; g_data = '0; g_par_in = 1'b0; g_chk = 1'b0;
      par_inh = 1'b0; alarm_clr = 1'b0;
      sw_load = 1'b0; sw_data = '0;
      test_reset();
      step();
      test_sreg();
      test_gen();
      test_check();
      test_back_to_back();
      test_reset_inflight();
      test_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
